call_stack: RTL and testbench



---
 rtl/call_stack.sv | 100 ++++++++++
 tb/tb_call_stack.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// Return-address LIFO feeding the PC load path: registered top-of-stack,
// full/empty decode and sticky overflow/underflow error flags.
module call_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_replace;
    logic             w_append;
    logic             w_remove;
    logic             w_wr_en;
    logic [CW-1:0]    w_top;
    logic [CW-1:0]    w_below;
    logic [AW-1:0]    w_wr_idx;
    logic [WIDTH-1:0] w_below_val;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_top   = r_count - CW'(1);
    assign w_below = r_count - CW'(2);

    // push+pop on a non-empty stack overwrites the top in place
    assign w_replace = push && pop && !w_empty;
    // push+pop on an empty stack still performs the push
    assign w_append  = push && !w_full && !w_replace;
    assign w_remove  = pop && !push && !w_empty;
    assign w_wr_en   = w_replace || w_append;
    assign w_wr_idx  = w_replace ? w_top[AW-1:0] : r_count[AW-1:0];

    // The entry exposed once the current top is removed; 0 when nothing remains.
    assign w_below_val = (r_count >= CW'(2)) ? r_mem[w_below[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= '0;
            r_dout      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_append) begin
                r_count <= r_count + CW'(1);
                r_dout  <= din;
            end else if (w_replace) begin
                r_dout  <= din;
            end else if (w_remove) begin
                r_count <= w_top;
                r_dout  <= w_below_val;
            end

            if (push && !pop && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end

            if (pop && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign dout      = r_dout;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_call_stack.sv
// Directed-vector bench for call_stack (WIDTH=16, DEPTH=8) with
// hand-computed expectations for each scenario.
module tb_call_stack;
    logic        clk;
    logic        rst;
    logic        push;
    logic        pop;
    logic        clr_err;
    logic [15:0] din;
    logic [15:0] dout;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int tests_run = 0;
    int tests_failed = 0;

    call_stack #(.WIDTH(16), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .clr_err  (clr_err),
        .din      (din),
        .dout     (dout),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies one cycle of inputs, lets the edge happen, samples 1 time unit later.
    task automatic step(input logic p, input logic q, input logic c, input logic [15:0] d);
        push = p; pop = q; clr_err = c; din = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        $display("[TB] t=%0t push=%0b pop=%0b clr=%0b din=%h -> dout=%h count=%0d e=%0b f=%0b ov=%0b un=%0b",
                 $time, p, q, c, d, dout, count, empty, full, overflow, underflow);
    endtask

    task automatic test_reset;
        tests_run++; if (count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests_run++; if (dout !== 16'h0000) begin tests_failed++; $display("FAIL reset_dout got=%h exp=0000", dout); end
        tests_run++; if (empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("FAIL reset_status got e=%0b f=%0b exp e=1 f=0", empty, full); end
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 16'h1111);
        step(1'b1, 1'b0, 1'b0, 16'h2222);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);   // underflow, so reset must clear a flag
        tests_run++; if (underflow !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_underflow got=%0b exp=1", underflow); end
        step(1'b1, 1'b0, 1'b0, 16'h3333);
        push = 1'b1; din = 16'h4444;
        #2 rst = 1'b0;
        #1;
        $display("[TB] t=%0t async reset asserted -> dout=%h count=%0d", $time, dout, count);
        tests_run++; if (count !== 4'd0) begin tests_failed++; $display("FAIL midreset_count got=%0d exp=0", count); end
        tests_run++; if (dout !== 16'h0000) begin tests_failed++; $display("FAIL midreset_dout got=%h exp=0000", dout); end
        tests_run++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_flags got e=%0b f=%0b ov=%0b un=%0b exp 1 0 0 0", empty, full, overflow, underflow); end
        push = 1'b0;
        #2 rst = 1'b1;
        #1;
    endtask

    task automatic test_lifo;
        step(1'b1, 1'b0, 1'b0, 16'h0010);
        step(1'b1, 1'b0, 1'b0, 16'h0020);
        step(1'b1, 1'b0, 1'b0, 16'h0030);
        tests_run++; if (dout !== 16'h0030 || count !== 4'd3) begin tests_failed++; $display("FAIL lifo_push got dout=%h count=%0d exp 0030 3", dout, count); end
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        tests_run++; if (dout !== 16'h0020 || count !== 4'd2) begin tests_failed++; $display("FAIL lifo_pop1 got dout=%h count=%0d exp 0020 2", dout, count); end
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        tests_run++; if (dout !== 16'h0010 || count !== 4'd1) begin tests_failed++; $display("FAIL lifo_pop2 got dout=%h count=%0d exp 0010 1", dout, count); end
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        tests_run++; if (dout !== 16'h0000 || count !== 4'd0 || empty !== 1'b1) begin tests_failed++; $display("FAIL lifo_pop3 got dout=%h count=%0d e=%0b exp 0000 0 1", dout, count, empty); end
        tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL lifo_no_underflow got=%0b exp=0", underflow); end
    endtask

    task automatic test_full_overflow;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'(i));
            tests_run++; if (count !== 4'(i) || dout !== 16'(i)) begin tests_failed++; $display("FAIL fill_%0d got dout=%h count=%0d exp %h %0d", i, dout, count, 16'(i), i); end
        end
        tests_run++; if (full !== 1'b1 || empty !== 1'b0) begin tests_failed++; $display("FAIL full_flag got f=%0b e=%0b exp f=1 e=0", full, empty); end
        step(1'b1, 1'b0, 1'b0, 16'hFFFF);
        tests_run++; if (count !== 4'd8 || dout !== 16'h0008) begin tests_failed++; $display("FAIL overflow_hold got dout=%h count=%0d exp 0008 8", dout, count); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL overflow_set got=%0b exp=1", overflow); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL overflow_sticky got=%0b exp=1", overflow); end
        step(1'b1, 1'b0, 1'b1, 16'hEEEE);   // clear collides with a new overflow
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL overflow_priority got=%0b exp=1", overflow); end
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL overflow_clear got=%0b exp=0", overflow); end
    endtask

    task automatic test_push_pop_full;
        step(1'b1, 1'b1, 1'b0, 16'hABCD);
        tests_run++; if (count !== 4'd8 || dout !== 16'hABCD) begin tests_failed++; $display("FAIL replace_full got dout=%h count=%0d exp ABCD 8", dout, count); end
        tests_run++; if (overflow !== 1'b0 || underflow !== 1'b0) begin tests_failed++; $display("FAIL replace_flags got ov=%0b un=%0b exp 0 0", overflow, underflow); end
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        tests_run++; if (dout !== 16'h0007 || count !== 4'd7 || full !== 1'b0) begin tests_failed++; $display("FAIL replace_pop got dout=%h count=%0d f=%0b exp 0007 7 0", dout, count, full); end
        for (int i = 6; i >= 0; i--) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000);
            tests_run++; if (dout !== 16'(i) || count !== 4'(i)) begin tests_failed++; $display("FAIL drain_%0d got dout=%h count=%0d exp %h %0d", i, dout, count, 16'(i), i); end
        end
    endtask

    task automatic test_underflow;
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        tests_run++; if (count !== 4'd0 || dout !== 16'h0000 || underflow !== 1'b1) begin tests_failed++; $display("FAIL underflow_pop got dout=%h count=%0d un=%0b exp 0000 0 1", dout, count, underflow); end
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL underflow_clear got=%0b exp=0", underflow); end
        step(1'b1, 1'b1, 1'b0, 16'h1234);
        tests_run++; if (count !== 4'd1 || dout !== 16'h1234 || underflow !== 1'b1) begin tests_failed++; $display("FAIL pushpop_empty got dout=%h count=%0d un=%0b exp 1234 1 1", dout, count, underflow); end
        step(1'b0, 1'b1, 1'b1, 16'h0000);   // legal pop, clear wins
        tests_run++; if (count !== 4'd0 || underflow !== 1'b0) begin tests_failed++; $display("FAIL pop_clear got count=%0d un=%0b exp 0 0", count, underflow); end
        step(1'b0, 1'b1, 1'b1, 16'h0000);   // error and clear together, error wins
        tests_run++; if (underflow !== 1'b1 || count !== 4'd0) begin tests_failed++; $display("FAIL underflow_priority got un=%0b count=%0d exp 1 0", underflow, count); end
        step(1'b0, 1'b0, 1'b1, 16'h0000);
    endtask

    task automatic test_pc_handoff;
        logic [15:0] pc_load;
        step(1'b1, 1'b0, 1'b0, 16'h87AB);
        pop = 1'b1;
        @(negedge clk);
        pc_load = dout;
        $display("[TB] t=%0t consumer sampled dout=%h during pop", $time, pc_load);
        tests_run++; if (pc_load !== 16'h87AB) begin tests_failed++; $display("FAIL handoff_value got=%h exp=87AB", pc_load); end
        @(posedge clk);
        #1;
        pop = 1'b0;
        tests_run++; if (count !== 4'd0 || empty !== 1'b1 || dout !== 16'h0000) begin tests_failed++; $display("FAIL handoff_count got count=%0d e=%0b dout=%h exp 0 1 0000", count, empty, dout); end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 1'b0, 1'b0, 16'hA000);
        step(1'b1, 1'b0, 1'b0, 16'hB000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        tests_run++; if (dout !== 16'hA000 || count !== 4'd1) begin tests_failed++; $display("FAIL b2b_pop got dout=%h count=%0d exp A000 1", dout, count); end
        step(1'b1, 1'b0, 1'b0, 16'hC000);
        tests_run++; if (dout !== 16'hC000 || count !== 4'd2) begin tests_failed++; $display("FAIL b2b_push got dout=%h count=%0d exp C000 2", dout, count); end
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        tests_run++; if (dout !== 16'h0000 || count !== 4'd0 || underflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain got dout=%h count=%0d un=%0b exp 0000 0 0", dout, count, underflow); end
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = 16'h0000;
        #3;
        test_reset;
        test_lifo;
        test_full_overflow;
        test_push_pop_full;
        test_underflow;
        test_pc_handoff;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout tests_run=%0d exp completion", tests_run);
        $fatal(1, "timeout");
    end

endmodule
